// File: rtl/bumpy_play_controller.sv
// Frame-level game sequencer: captures one move command per frame from raw keys, forwards brick
// collisions, and runs the death / respawn / level-done / game-over flow for the motion block.
module bumpy_play_controller #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned LIVES_W      = 2,
    parameter int unsigned DEATH_FRAMES = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               rightN,
    input  logic               leftN,
    input  logic               jumpN,
    input  logic               brickHit,
    input  logic               hazardHit,
    input  logic               goalHit,
    input  logic [3:0]         HitEdgeCode,
    output logic               rightCmdN,
    output logic               leftCmdN,
    output logic               jumpCmdN,
    output logic               collisionOut,
    output logic [3:0]         hitEdgeOut,
    output logic               moveResetN,
    output logic [LIVES_W-1:0] lives,
    output logic               levelDone,
    output logic               gameOver
);

    typedef enum logic [2:0] {
        StPlay,
        StDying,
        StRespawn,
        StLevelDone,
        StGameOver
    } state_t;

    localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LivesOne  = LIVES_W'(1);
    localparam logic [5:0]         DeathLast = 6'(DEATH_FRAMES - 1);

    state_t     state;
    logic       right_prev;
    logic       left_prev;
    logic       jump_prev;
    logic       pend_valid;
    // Commands are one-hot {jump, right, left}; all-zero means no command.
    logic [2:0] pend_cmd;
    logic [2:0] issue_cmd;
    logic [2:0] new_cmd;
    logic [5:0] frame_cnt;
    logic       right_fall;
    logic       left_fall;
    logic       jump_fall;

    assign right_fall = right_prev & ~rightN;
    assign left_fall  = left_prev & ~leftN;
    assign jump_fall  = jump_prev & ~jumpN;

    always_comb begin
        new_cmd = 3'b000;
        if (jump_fall) begin
            new_cmd = 3'b100;
        end else if (right_fall) begin
            new_cmd = 3'b010;
        end else if (left_fall) begin
            new_cmd = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= StPlay;
            right_prev   <= 1'b1;
            left_prev    <= 1'b1;
            jump_prev    <= 1'b1;
            pend_valid   <= 1'b0;
            pend_cmd     <= 3'b000;
            issue_cmd    <= 3'b000;
            frame_cnt    <= 6'd0;
            rightCmdN    <= 1'b1;
            leftCmdN     <= 1'b1;
            jumpCmdN     <= 1'b1;
            collisionOut <= 1'b0;
            hitEdgeOut   <= 4'b0000;
            moveResetN   <= 1'b1;
            lives        <= LivesInit;
            levelDone    <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            right_prev   <= rightN;
            left_prev    <= leftN;
            jump_prev    <= jumpN;
            moveResetN   <= 1'b1;
            collisionOut <= 1'b0;
            hitEdgeOut   <= 4'b0000;
            rightCmdN    <= 1'b1;
            leftCmdN     <= 1'b1;
            jumpCmdN     <= 1'b1;

            unique case (state)
                StPlay: begin
                    collisionOut <= brickHit;
                    hitEdgeOut   <= brickHit ? HitEdgeCode : 4'b0000;
                    if (hazardHit) begin
                        state      <= StDying;
                        pend_valid <= 1'b0;
                        pend_cmd   <= 3'b000;
                        issue_cmd  <= 3'b000;
                        frame_cnt  <= 6'd0;
                    end else if (goalHit) begin
                        state      <= StLevelDone;
                        levelDone  <= 1'b1;
                        pend_valid <= 1'b0;
                        pend_cmd   <= 3'b000;
                        issue_cmd  <= 3'b000;
                    end else begin
                        jumpCmdN  <= ~issue_cmd[2];
                        rightCmdN <= ~issue_cmd[1];
                        leftCmdN  <= ~issue_cmd[0];
                        if (startOfFrame) begin
                            // Transfer first; an edge on this same clk refills pending.
                            issue_cmd  <= pend_valid ? pend_cmd : 3'b000;
                            pend_valid <= (new_cmd != 3'b000);
                            pend_cmd   <= new_cmd;
                        end else if (!pend_valid && (new_cmd != 3'b000)) begin
                            pend_valid <= 1'b1;
                            pend_cmd   <= new_cmd;
                        end
                    end
                end

                StDying: begin
                    if (startOfFrame) begin
                        if (frame_cnt == DeathLast) begin
                            frame_cnt <= 6'd0;
                            if (lives <= LivesOne) begin
                                lives    <= '0;
                                gameOver <= 1'b1;
                                state    <= StGameOver;
                            end else begin
                                lives      <= lives - LivesOne;
                                moveResetN <= 1'b0;
                                state      <= StRespawn;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 6'd1;
                        end
                    end
                end

                StRespawn: begin
                    state <= StPlay;
                end

                StLevelDone: begin
                    if (jump_fall) begin
                        moveResetN <= 1'b0;
                        levelDone  <= 1'b0;
                        state      <= StPlay;
                    end
                end

                StGameOver: begin
                    if (jump_fall) begin
                        moveResetN <= 1'b0;
                        gameOver   <= 1'b0;
                        lives      <= LivesInit;
                        state      <= StPlay;
                    end
                end

                default: begin
                    state <= StPlay;
                end
            endcase
        end
    end

endmodule
